sobel_threshold: RTL and testbench

//  Streaming 3x3 Sobel edge detector feeding the erode stage. Takes one RGB444 pixel per clk
//  in raster order (hcount/vcount) and converts it to luma. Buffers two prior lines and

---
 rtl/sobel_threshold_if.sv | 21 ++
 rtl/sobel_threshold.sv | 129 ++++++++++++
 tb/tb_sobel_threshold.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sobel_threshold_if.sv
// Pixel-in / edge-flag-out bundle of the Sobel stage.
// The pixel source drives the master side; the Sobel block sits on the slave side.
interface sobel_threshold_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic [11:0] pixel_in;
  logic        sobel_value;
  logic        sobel_valid;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;

  modport master (
    output hcount, vcount, pixel_in,
    input  sobel_value, sobel_valid, hcount_out, vcount_out
  );

  modport slave (
    input  hcount, vcount, pixel_in,
    output sobel_value, sobel_valid, hcount_out, vcount_out
  );
endinterface

// File: rtl/sobel_threshold.sv
// Streaming 3x3 Sobel edge flag on RGB444 luma. 3 clk latency from sample to flag.
// No back-pressure: one result per active sample, downstream must always accept.
module sobel_threshold #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int THRESHOLD = 96
) (
  input  logic             clk,
  input  logic             rst,
  sobel_threshold_if.slave px
);
  localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  typedef enum logic {WAIT_SOF = 1'b0, RUN = 1'b1} state_t;
  state_t state_q, state_d;

  logic          active, sof, armed, emit;
  logic [AW-1:0] addr;
  logic [5:0]    luma;

  logic [5:0] lb_top_q [H_ACTIVE];
  logic [5:0] lb_mid_q [H_ACTIVE];
  logic [5:0] win_q [3][3];
  logic [5:0] win_d [3][3];

  logic        vld1_q, vld2_q, vld3_q;
  logic [10:0] x1_q, y1_q, x2_q, y2_q, x3_q, y3_q;
  logic [8:0]  mag2_q;
  logic        val3_q;

  logic signed [9:0] gx, gy;
  logic [9:0]        ax, ay;
  logic [8:0]        mag;

  assign active = (px.hcount < 11'(H_ACTIVE)) && (px.vcount < 11'(V_ACTIVE));
  assign sof    = active && (px.hcount == 11'd0) && (px.vcount == 11'd0);
  assign emit   = active && armed && (px.hcount != 11'd0) && (px.vcount != 11'd0);
  assign addr   = px.hcount[AW-1:0];
  assign luma   = {2'b00, px.pixel_in[11:8]} + {1'b0, px.pixel_in[7:4], 1'b0}
                + {2'b00, px.pixel_in[3:0]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_SOF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == WAIT_SOF && sof) state_d = RUN;
  end

  // The start-of-frame sample itself is already eligible.
  always_comb begin
    armed = (state_q == RUN) || sof;
  end

  // Line buffers: read-before-write, the row moving from mid to top as it ages.
  always_ff @(posedge clk) begin
    if (!rst && active) begin
      lb_mid_q[addr] <= luma;
      lb_top_q[addr] <= lb_mid_q[addr];
    end
  end

  always_comb begin
    win_d = win_q;
    if (active) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb_top_q[addr];
      win_d[1][2] = lb_mid_q[addr];
      win_d[2][2] = luma;
    end
  end

  function automatic logic signed [9:0] sx(input logic [5:0] a);
    return signed'({4'b0000, a});
  endfunction

  always_comb begin
    gx = (sx(win_q[0][2]) + (sx(win_q[1][2]) <<< 1) + sx(win_q[2][2]))
       - (sx(win_q[0][0]) + (sx(win_q[1][0]) <<< 1) + sx(win_q[2][0]));
    gy = (sx(win_q[2][0]) + (sx(win_q[2][1]) <<< 1) + sx(win_q[2][2]))
       - (sx(win_q[0][0]) + (sx(win_q[0][1]) <<< 1) + sx(win_q[0][2]));
    ax  = gx[9] ? 10'(-gx) : 10'(gx);
    ay  = gy[9] ? 10'(-gy) : 10'(gy);
    mag = 9'(ax + ay);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
      vld1_q <= 1'b0;
      vld2_q <= 1'b0;
      vld3_q <= 1'b0;
      x1_q   <= '0;
      y1_q   <= '0;
      x2_q   <= '0;
      y2_q   <= '0;
      x3_q   <= '0;
      y3_q   <= '0;
      mag2_q <= '0;
      val3_q <= 1'b0;
    end else begin
      win_q  <= win_d;
      vld1_q <= emit;
      x1_q   <= px.hcount - 11'd1;
      y1_q   <= px.vcount - 11'd1;
      vld2_q <= vld1_q;
      x2_q   <= x1_q;
      y2_q   <= y1_q;
      mag2_q <= mag;
      vld3_q <= vld2_q;
      x3_q   <= x2_q;
      y3_q   <= y2_q;
      // Window on row/column 0 holds wrap-around data, so the border is forced clear.
      val3_q <= (x2_q != 11'd0) && (y2_q != 11'd0) && (mag2_q >= 9'(THRESHOLD));
    end
  end

  assign px.sobel_value = val3_q;
  assign px.sobel_valid = vld3_q;
  assign px.hcount_out  = x3_q;
  assign px.vcount_out  = y3_q;
endmodule

// File: tb/tb_sobel_threshold.sv
// Directed frames against sobel_threshold with a frame-level Sobel reference.
module tb_sobel_threshold;
  localparam int H = 16;
  localparam int V = 8;
  localparam int TH = 96;
  localparam int NRES = (H - 1) * (V - 1);

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  sobel_threshold_if bus();

  sobel_threshold #(.H_ACTIVE(H), .V_ACTIVE(V), .THRESHOLD(TH)) dut (
    .clk (clk),
    .rst (rst),
    .px  (bus)
  );

  typedef struct {
    int x;
    int y;
    int val;
    int cyc;
  } res_t;

  res_t        res_q[$];
  logic [11:0] img [V][H];
  int          in_cyc [V][H];
  int          saved [NRES];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int h, v;
    h = int'(bus.hcount);
    v = int'(bus.vcount);
    if (h < H && v < V) in_cyc[v][h] = cyc;
    if (bus.sobel_valid)
      res_q.push_back('{int'(bus.hcount_out), int'(bus.vcount_out), int'(bus.sobel_value), cyc});
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lum(input int v, input int h);
    logic [11:0] p;
    p = img[v][h];
    return int'(p[11:8]) + 2 * int'(p[7:4]) + int'(p[3:0]);
  endfunction

  function automatic int model(input int x, input int y);
    int gx, gy, w;
    if (x == 0 || y == 0) return 0;
    gx = 0;
    gy = 0;
    for (int k = 0; k < 3; k++) begin
      w = (k == 1) ? 2 : 1;
      gx += w * (lum(y - 1 + k, x + 1) - lum(y - 1 + k, x - 1));
      gy += w * (lum(y + 1, x - 1 + k) - lum(y - 1, x - 1 + k));
    end
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return (gx + gy >= TH) ? 1 : 0;
  endfunction

  task automatic drive(input int h, input int v, input logic [11:0] p, input bit r);
    @(posedge clk);
    #1;
    rst          = r;
    bus.hcount   = 11'(h);
    bus.vcount   = 11'(v);
    bus.pixel_in = p;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, " value"}, int'(bus.sobel_value), 0);
    chk({tag, " valid"}, int'(bus.sobel_valid), 0);
    chk({tag, " hcount_out"}, int'(bus.hcount_out), 0);
    chk({tag, " vcount_out"}, int'(bus.vcount_out), 0);
  endtask

  task automatic send_frame(input int blank, input int rh, input int rv);
    bit pend;
    bit r;
    logic [11:0] p;
    pend = 1'b0;
    for (int v = 0; v < V; v++) begin
      for (int h = 0; h < H + blank; h++) begin
        p = (h < H) ? img[v][h] : 12'($urandom);
        r = (h == rh) && (v == rv);
        drive(h, v, p, r);
        if (pend) begin
          @(negedge clk);
          check_outputs_zero("after reset");
          res_q.delete();
          pend = 1'b0;
        end
        if (r) pend = 1'b1;
      end
    end
    repeat (5) drive(2047, 2047, 12'h000, 1'b0);
  endtask

  task automatic check_frame(input string tag, input int exp_ones, input bit save, input bit cmp);
    int ones;
    ones = 0;
    chk({tag, " count"}, res_q.size(), NRES);
    for (int i = 0; i < res_q.size() && i < NRES; i++) begin
      int x, y;
      x = i % (H - 1);
      y = i / (H - 1);
      chk({tag, " hcount_out"}, res_q[i].x, x);
      chk({tag, " vcount_out"}, res_q[i].y, y);
      chk({tag, " value"}, res_q[i].val, model(x, y));
      chk({tag, " latency"}, res_q[i].cyc - in_cyc[y + 1][x + 1], 3);
      if (x == 0 || y == 0) chk({tag, " border"}, res_q[i].val, 0);
      ones += res_q[i].val;
      if (save) saved[i] = res_q[i].val;
      if (cmp) chk({tag, " vs unblanked"}, res_q[i].val, saved[i]);
    end
    if (exp_ones >= 0) chk({tag, " edge count"}, ones, exp_ones);
    res_q.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.hcount   = 11'd2047;
    bus.vcount   = 11'd2047;
    bus.pixel_in = 12'h000;
    repeat (3) drive(2047, 2047, 12'h000, 1'b1);
    @(negedge clk);
    check_outputs_zero("reset state");
    repeat (2) drive(2047, 2047, 12'h000, 1'b0);
    chk("no valid before frame", res_q.size(), 0);

    // Flat white frame: no gradient anywhere.
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) img[v][h] = 12'hFFF;
    send_frame(0, -1, -1);
    check_frame("flat", 0, 1'b0, 1'b0);

    // Vertical step at x=8: M=240 at centres x=7,8 on rows 1..6.
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) img[v][h] = (h < 8) ? 12'h000 : 12'hFFF;
    send_frame(0, -1, -1);
    check_frame("vstep", 12, 1'b0, 1'b0);

    // Horizontal step to L=24 gives M=96, exactly at threshold, on rows 3,4 (x=1..14).
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) img[v][h] = (v < 4) ? 12'h000 : 12'h666;
    send_frame(0, -1, -1);
    check_frame("thr96", 28, 1'b0, 1'b0);

    // L=23 gives M=92, just below threshold.
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) img[v][h] = (v < 4) ? 12'h000 : 12'h566;
    send_frame(0, -1, -1);
    check_frame("thr92", 0, 1'b0, 1'b0);

    // Checkerboard: symmetric neighbourhoods cancel, border must stay 0.
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) img[v][h] = (((h + v) % 2) == 1) ? 12'hFFF : 12'h000;
    send_frame(0, -1, -1);
    check_frame("checker", 0, 1'b0, 1'b0);

    // Mid-frame reset at (5,3): quiet until the next start of frame.
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) img[v][h] = 12'($urandom);
    send_frame(0, -1, -1);
    check_frame("random", -1, 1'b0, 1'b0);
    send_frame(0, 5, 3);
    chk("quiet after reset", res_q.size(), 0);
    send_frame(0, -1, -1);
    check_frame("rearmed", -1, 1'b0, 1'b0);

    // Same frame with and without horizontal blanking.
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) img[v][h] = 12'($urandom);
    send_frame(0, -1, -1);
    check_frame("noblank", -1, 1'b1, 1'b0);
    send_frame(5, -1, -1);
    check_frame("blank", -1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
